if_prefetch_unit: RTL and testbench

Instruction-fetch front end that sits directly upstream of the pipelined core's IF/ID register. It issues sequential word fetches to instruction memory over a request/grant, in-order response interface and buffers returned words with their PCs in a DEPTH-entry FIFO. It presents {pc, instr} to decode with a valid/ready handshake. Taken-branch or jump redirects flush the buffer, and responses already in flight are discarded.

---
 rtl/if_prefetch_unit.sv | 163 ++++++++++++++++
 tb/tb_if_prefetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit: issues sequential word fetches, buffers
// returned words with their PCs in a small FIFO and hands them to decode.
// Start and redirect flush the buffer and drop any responses still in flight.
module if_prefetch_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [31:0] i_start_addr,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_addr,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr,
   input  logic        i_ready,
   output logic        o_misaligned
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic          misaligned_q, misaligned_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pc_mem_q    [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];

   logic          load;
   logic [31:0]   load_pc;
   logic          push;
   logic          pop;
   logic          req;
   logic          valid;
   logic [CW:0]   fill_sum;
   logic [CW:0]   inflight_sum;

   // Request and output-valid gating; both are suppressed while a PC load is pending.
   always_comb begin
      load         = i_start || (i_redirect && (state_q == RUN));
      load_pc      = i_start ? i_start_addr : i_redirect_addr;
      fill_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
      inflight_sum = {1'b0, discard_q} + {1'b0, outstanding_q};
      req          = (state_q == RUN) && !i_start && !i_redirect &&
                     (fill_sum < DEPTH_W) && (inflight_sum < DEPTH_W);
      valid        = (state_q == RUN) && (count_q != '0) && !i_start && !i_redirect;
      pop          = valid && i_ready;
   end

   // Next-state for the FSM, PCs, counters and FIFO pointers.
   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      misaligned_d  = misaligned_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      push          = 1'b0;
      if (load) begin
         fetch_pc_d    = load_pc;
         resp_pc_d     = load_pc;
         count_d       = '0;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         outstanding_d = '0;
         if (i_imem_rvalid && ((discard_q != '0) || (outstanding_q != '0))) begin
            discard_d = discard_q + outstanding_q - CW'(1);
         end else begin
            discard_d = discard_q + outstanding_q;
         end
         if (load_pc[1:0] != 2'b00) begin
            misaligned_d = 1'b1;
            state_d      = ERR;
         end else begin
            misaligned_d = 1'b0;
            state_d      = RUN;
         end
      end else begin
         if (req && i_imem_gnt) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (i_imem_rvalid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else if (outstanding_q != '0) begin
               push = 1'b1;
            end
         end
         outstanding_d = outstanding_q + CW'(req && i_imem_gnt) - CW'(push);
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         fetch_pc_q    <= '0;
         resp_pc_q     <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         misaligned_q  <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         misaligned_q  <= misaligned_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // FIFO storage; cleared on reset so the head outputs read zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]    <= resp_pc_q;
         instr_mem_q[wr_ptr_q] <= i_imem_rdata;
      end
   end

   assign o_imem_req   = req;
   assign o_imem_addr  = fetch_pc_q;
   assign o_valid      = valid;
   assign o_pc         = pc_mem_q[rd_ptr_q];
   assign o_instr      = instr_mem_q[rd_ptr_q];
   assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: table-driven fetch/wrap vectors
// plus directed sequences for back-pressure, redirect, misalignment and reset.
module tb_if_prefetch_unit;

   localparam logic [31:0] MAGIC = 32'hA5A5A5A5;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [31:0] i_start_addr;
   logic        i_redirect;
   logic [31:0] i_redirect_addr;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic        i_ready;
   logic        o_misaligned;

   if_prefetch_unit #(.DEPTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (i_start),
      .i_start_addr    (i_start_addr),
      .i_redirect      (i_redirect),
      .i_redirect_addr (i_redirect_addr),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_gnt      (i_imem_gnt),
      .i_imem_rvalid   (i_imem_rvalid),
      .i_imem_rdata    (i_imem_rdata),
      .o_valid         (o_valid),
      .o_pc            (o_pc),
      .o_instr         (o_instr),
      .i_ready         (i_ready),
      .o_misaligned    (o_misaligned)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } resp_t;

   typedef struct {
      logic        start;
      logic [31:0] start_addr;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   resp_t       resp_q[$];
   logic [31:0] grant_log[$];
   logic [31:0] pop_pc_log[$];
   logic [31:0] pop_instr_log[$];
   vec_t        vecs[12];

   int          test_cnt = 0;
   int          fail_cnt = 0;
   int          cyc = 0;
   int          lat = 1;
   logic        gnt_en = 1'b1;
   logic        obs_req, obs_valid, obs_mis;
   logic [31:0] obs_addr, obs_pc, obs_instr;
   logic        bad_req, bad_valid, bad_mis;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle with an in-order memory model of latency lat.
   task automatic applyStimulus();
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = resp_q[0].addr ^ MAGIC;
         resp_q.delete(0);
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = 32'h0;
      end
      i_imem_gnt = gnt_en;
      #1;
      obs_req   = o_imem_req;
      obs_addr  = o_imem_addr;
      obs_valid = o_valid;
      obs_pc    = o_pc;
      obs_instr = o_instr;
      obs_mis   = o_misaligned;
      if (o_imem_req && i_imem_gnt) begin
         resp_q.push_back('{addr: o_imem_addr, due: cyc + lat});
         grant_log.push_back(o_imem_addr);
      end
      if (o_valid && i_ready) begin
         pop_pc_log.push_back(o_pc);
         pop_instr_log.push_back(o_instr);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clearLogs();
      grant_log.delete();
      pop_pc_log.delete();
      pop_instr_log.delete();
   endtask

   task automatic runUntilPops(input int n, input int budget, input string name);
      int k = 0;
      while (pop_pc_log.size() < n && k < budget) begin
         applyStimulus();
         k++;
      end
      checkOutput({name, "_pops"}, 32'(pop_pc_log.size() >= n), 32'd1);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h00000100, 1'b0, 32'h00000000, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 32'h0,        1'b1, 32'h00000100, 1'b0, 32'h0};
      vecs[2]  = '{1'b0, 32'h0,        1'b1, 32'h00000104, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h0,        1'b1, 32'h00000108, 1'b1, 32'h00000100};
      vecs[4]  = '{1'b0, 32'h0,        1'b1, 32'h0000010C, 1'b1, 32'h00000104};
      vecs[5]  = '{1'b0, 32'h0,        1'b1, 32'h00000110, 1'b1, 32'h00000108};
      vecs[6]  = '{1'b1, 32'hFFFFFFF8, 1'b0, 32'h00000114, 1'b0, 32'h0};
      vecs[7]  = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFF8, 1'b0, 32'h0};
      vecs[8]  = '{1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 32'h0,        1'b1, 32'h00000000, 1'b1, 32'hFFFFFFF8};
      vecs[10] = '{1'b0, 32'h0,        1'b1, 32'h00000004, 1'b1, 32'hFFFFFFFC};
      vecs[11] = '{1'b0, 32'h0,        1'b1, 32'h00000008, 1'b1, 32'h00000000};

      rst_n = 1'b0;
      i_start = 1'b0; i_start_addr = 32'h0;
      i_redirect = 1'b0; i_redirect_addr = 32'h0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
      i_ready = 1'b1;
      @(negedge clk);
      checkOutput("reset_req", {31'b0, o_imem_req}, 32'd0);
      checkOutput("reset_valid", {31'b0, o_valid}, 32'd0);
      checkOutput("reset_mis", {31'b0, o_misaligned}, 32'd0);
      checkOutput("reset_pc", o_pc, 32'd0);
      checkOutput("reset_instr", o_instr, 32'd0);
      checkOutput("reset_addr", o_imem_addr, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch from 0x100, then a restart that wraps the address space.
      for (int i = 0; i < 12; i++) begin
         i_start      = vecs[i].start;
         i_start_addr = vecs[i].start_addr;
         applyStimulus();
         i_start = 1'b0;
         checkOutput($sformatf("vec%0d_req", i), {31'b0, obs_req}, {31'b0, vecs[i].exp_req});
         checkOutput($sformatf("vec%0d_addr", i), obs_addr, vecs[i].exp_addr);
         checkOutput($sformatf("vec%0d_valid", i), {31'b0, obs_valid}, {31'b0, vecs[i].exp_valid});
         if (vecs[i].exp_valid) begin
            checkOutput($sformatf("vec%0d_pc", i), obs_pc, vecs[i].exp_pc);
            checkOutput($sformatf("vec%0d_instr", i), obs_instr, vecs[i].exp_pc ^ MAGIC);
         end
      end

      // Back-pressure: buffer fills after exactly four grants, then drains in order.
      i_ready = 1'b0;
      i_start = 1'b1; i_start_addr = 32'h100;
      applyStimulus();
      i_start = 1'b0;
      clearLogs();
      repeat (10) applyStimulus();
      checkOutput("bp_grants", 32'(grant_log.size()), 32'd4);
      checkOutput("bp_req_off", {31'b0, obs_req}, 32'd0);
      checkOutput("bp_valid", {31'b0, obs_valid}, 32'd1);
      checkOutput("bp_head_pc", obs_pc, 32'h100);
      i_ready = 1'b1;
      runUntilPops(5, 30, "bp");
      if (pop_pc_log.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_pop%0d_pc", i), pop_pc_log[i], 32'h100 + 32'(4 * i));
            checkOutput($sformatf("bp_pop%0d_instr", i), pop_instr_log[i], (32'h100 + 32'(4 * i)) ^ MAGIC);
         end
      end
      checkOutput("bp_grant_count", 32'(grant_log.size() >= 5), 32'd1);
      if (grant_log.size() >= 5) checkOutput("bp_resume_addr", grant_log[4], 32'h110);

      // Redirect with two responses still in flight (latency 3).
      lat = 3;
      i_start = 1'b1; i_start_addr = 32'h100;
      applyStimulus();
      i_start = 1'b0;
      applyStimulus();
      applyStimulus();
      gnt_en = 1'b0;
      i_redirect = 1'b1; i_redirect_addr = 32'h200;
      applyStimulus();
      i_redirect = 1'b0;
      gnt_en = 1'b1;
      checkOutput("rd_valid_during", {31'b0, obs_valid}, 32'd0);
      clearLogs();
      applyStimulus();
      checkOutput("rd_empty_after", {31'b0, obs_valid}, 32'd0);
      runUntilPops(1, 30, "rd");
      if (pop_pc_log.size() >= 1) begin
         checkOutput("rd_first_pc", pop_pc_log[0], 32'h200);
         checkOutput("rd_first_instr", pop_instr_log[0], 32'h200 ^ MAGIC);
      end
      if (grant_log.size() >= 1) checkOutput("rd_first_grant", grant_log[0], 32'h200);

      // Misaligned redirect parks the unit until a new start.
      i_redirect = 1'b1; i_redirect_addr = 32'h202;
      applyStimulus();
      i_redirect = 1'b0;
      bad_req = 1'b0; bad_valid = 1'b0; bad_mis = 1'b0;
      repeat (10) begin
         applyStimulus();
         bad_req   = bad_req | obs_req;
         bad_valid = bad_valid | obs_valid;
         bad_mis   = bad_mis | !obs_mis;
      end
      checkOutput("mis_req_held_low", {31'b0, bad_req}, 32'd0);
      checkOutput("mis_valid_held_low", {31'b0, bad_valid}, 32'd0);
      checkOutput("mis_flag_held_high", {31'b0, bad_mis}, 32'd0);
      i_start = 1'b1; i_start_addr = 32'h300;
      applyStimulus();
      i_start = 1'b0;
      clearLogs();
      applyStimulus();
      checkOutput("mis_cleared", {31'b0, obs_mis}, 32'd0);
      runUntilPops(1, 30, "mis");
      if (pop_pc_log.size() >= 1) checkOutput("mis_resume_pc", pop_pc_log[0], 32'h300);
      if (grant_log.size() >= 1) checkOutput("mis_resume_grant", grant_log[0], 32'h300);

      // Reset in the middle of operation with three buffered and one in flight.
      gnt_en = 1'b0;
      repeat (5) applyStimulus();
      lat = 1;
      gnt_en = 1'b1;
      repeat (4) applyStimulus();
      i_ready = 1'b0;
      i_start = 1'b1; i_start_addr = 32'h400;
      applyStimulus();
      i_start = 1'b0;
      grant_log.delete();
      repeat (4) applyStimulus();
      checkOutput("rst_pre_grants", 32'(grant_log.size()), 32'd4);
      #1;
      checkOutput("rst_pre_valid", {31'b0, o_valid}, 32'd1);
      checkOutput("rst_pre_pc", o_pc, 32'h400);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", {31'b0, o_valid}, 32'd0);
      checkOutput("rst_async_req", {31'b0, o_imem_req}, 32'd0);
      checkOutput("rst_async_mis", {31'b0, o_misaligned}, 32'd0);
      checkOutput("rst_async_pc", o_pc, 32'd0);
      resp_q.delete();
      @(negedge clk);
      cyc++;
      repeat (2) applyStimulus();
      rst_n = 1'b1;
      i_ready = 1'b1;
      resp_q.push_back('{addr: 32'h40C, due: cyc});
      bad_req = 1'b0; bad_valid = 1'b0;
      repeat (5) begin
         applyStimulus();
         bad_req   = bad_req | obs_req;
         bad_valid = bad_valid | obs_valid;
      end
      checkOutput("rst_stale_req", {31'b0, bad_req}, 32'd0);
      checkOutput("rst_stale_valid", {31'b0, bad_valid}, 32'd0);
      checkOutput("rst_idle_addr", obs_addr, 32'd0);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
